// File: rtl/cache_mem_responder.sv
// ---------------------------------------------------------------------------
// cache_mem_responder
//
// Purpose:
//   Memory-side responder for a cache with 4-word (16-byte) lines. It serves
//   line fills (a 4-beat read burst after a fixed latency) and line writebacks
//   (4 data beats in, then a single ack after the same latency). The backing
//   store is MEM_WORDS 32-bit words. In simulation it starts out holding
//   mem[i] = i, and reset never clears it.
//
// Parameters:
//   LATENCY    cycles from request accept to first response beat (1..15)
//   MEM_WORDS  backing store depth in 32-bit words
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_rst          synchronous active-high reset
//   i_req_valid    cache presents a line request
//   o_req_ready    responder accepts a request this cycle (IDLE only)
//   i_req_write    1 = line writeback, 0 = line fill
//   i_req_addr     12-bit byte address; [11:4] selects the line
//   i_wdata_valid  writeback beat valid
//   o_wdata_ready  responder accepts a writeback beat
//   i_wdata        writeback beat data
//   o_rsp_valid    fill beat or writeback ack valid
//   i_rsp_ready    cache accepts the response beat
//   o_rsp_data     fill beat data, 0 on writeback ack
//   o_rsp_last     final fill beat, or the single writeback ack
//   o_fill_count   completed fills (saturating, stats build only)
//   o_wb_count     completed writebacks (saturating, stats build only)
//
// Configuration:
//   CACHE_MEM_STATS_EN  when defined, builds the saturating fill/writeback
//                       counters. When undefined, both count outputs are 0.
// ---------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [11:0] i_req_addr,
    input  logic        i_wdata_valid,
    output logic        o_wdata_ready,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_last,
    output logic [15:0] o_fill_count,
    output logic [15:0] o_wb_count
);

    localparam int         AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_DATA,
        WR_WAIT,
        WR_ACK
    } state_t;

    state_t      r_state;
    logic [7:0]  r_line;
    logic [1:0]  r_beat;
    logic [3:0]  r_lat_cnt;
    logic        r_req_ready;
    logic        r_wdata_ready;
    logic        r_rsp_valid;
    logic        r_rsp_last;
    logic [31:0] r_rsp_data;

    logic [31:0] w_mem_rdata [MEM_WORDS];
    logic        w_mem_we;
    logic [AW-1:0] w_wr_idx;
    logic        w_rsp_fire;
    logic [1:0]  w_beat_next;
    logic        w_unused_addr;

    // Word index of beat 'beat' within line 'line'. Beats always run 0..3,
    // starting at the line base regardless of the requested word.
    function automatic logic [AW-1:0] word_idx(input logic [7:0] line, input logic [1:0] beat);
        return AW'({line, beat});
    endfunction

    assign w_rsp_fire    = r_rsp_valid & i_rsp_ready;
    assign w_beat_next   = r_beat + 2'd1;
    assign w_wr_idx      = word_idx(r_line, r_beat);
    // Reset wins over a beat arriving on the same edge, so an abandoned
    // writeback never lands a word after reset is seen.
    assign w_mem_we      = (r_state == WR_DATA) & i_wdata_valid & ~i_rst;
    // The word/byte offset bits do not matter: whole lines are always moved.
    assign w_unused_addr = ^i_req_addr[3:0];

    // Backing store. Each word is its own register with a power-up value of
    // its index, so simulation starts with mem[i] = i. Reset does not touch it.
    for (genvar g = 0; g < MEM_WORDS; g++) begin : g_mem
        logic [31:0] r_word = 32'(g);

        always_ff @(posedge i_clk) begin
            if (w_mem_we && (w_wr_idx == AW'(g))) begin
                r_word <= i_wdata;
            end
        end

        assign w_mem_rdata[g] = r_word;
    end

    // Transaction FSM with registered handshake outputs. On entry to RD_BURST
    // and on every accepted beat, the data for the beat now being offered is
    // loaded, so o_rsp_data and o_rsp_last hold still while the cache stalls.
    // The latency counter loads LATENCY-1 on accept and the state moves on
    // when it reads 0. The first response therefore appears LATENCY edges
    // after the accepting edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_line        <= '0;
            r_beat        <= '0;
            r_lat_cnt     <= '0;
            r_req_ready   <= 1'b1;
            r_wdata_ready <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_last    <= 1'b0;
            r_rsp_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_line      <= i_req_addr[11:4];
                        r_beat      <= '0;
                        r_lat_cnt   <= LAT_LOAD;
                        r_req_ready <= 1'b0;
                        if (i_req_write) begin
                            r_state       <= WR_DATA;
                            r_wdata_ready <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state     <= RD_BURST;
                        r_beat      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b0;
                        r_rsp_data  <= w_mem_rdata[word_idx(r_line, 2'd0)];
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end

                RD_BURST: begin
                    if (w_rsp_fire) begin
                        if (r_rsp_last) begin
                            r_state     <= IDLE;
                            r_beat      <= '0;
                            r_rsp_valid <= 1'b0;
                            r_rsp_last  <= 1'b0;
                            r_rsp_data  <= '0;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_beat     <= w_beat_next;
                            r_rsp_data <= w_mem_rdata[word_idx(r_line, w_beat_next)];
                            r_rsp_last <= (w_beat_next == 2'd3);
                        end
                    end
                end

                WR_DATA: begin
                    if (i_wdata_valid) begin
                        if (r_beat == 2'd3) begin
                            r_state       <= WR_WAIT;
                            r_beat        <= '0;
                            r_wdata_ready <= 1'b0;
                            r_lat_cnt     <= LAT_LOAD;
                        end else begin
                            r_beat <= w_beat_next;
                        end
                    end
                end

                WR_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state     <= WR_ACK;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b1;
                        r_rsp_data  <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end

                WR_ACK: begin
                    if (w_rsp_fire) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_wdata_ready = r_wdata_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_last    = r_rsp_last;
    assign o_rsp_data    = r_rsp_data;

`ifdef CACHE_MEM_STATS_EN
    logic [15:0] r_fill_count;
    logic [15:0] r_wb_count;

    // Completion counters. A fill completes when its last beat is accepted,
    // and a writeback completes when its ack is accepted. Both stick at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fill_count <= '0;
            r_wb_count   <= '0;
        end else begin
            if (w_rsp_fire && (r_state == RD_BURST) && r_rsp_last && (r_fill_count != 16'hFFFF)) begin
                r_fill_count <= r_fill_count + 16'd1;
            end
            if (w_rsp_fire && (r_state == WR_ACK) && (r_wb_count != 16'hFFFF)) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
        end
    end

    assign o_fill_count = r_fill_count;
    assign o_wb_count   = r_wb_count;
`else
    assign o_fill_count = '0;
    assign o_wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_responder
//
// Directed bench for cache_mem_responder. It covers reset state, fill
// latency and data, writeback followed by a read-back, a stalled fill,
// back-to-back requests with req_valid held, reset in the middle of a
// writeback, and the completion counters.
// ---------------------------------------------------------------------------
module tb_cache_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [11:0] reqAddr = '0;
    logic        wdataValid = 1'b0;
    logic        wdataReady;
    logic [31:0] wdata = '0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [31:0] rspData;
    logic        rspLast;
    logic [15:0] fillCount;
    logic [15:0] wbCount;

    int          nAsserts = 0;
    int          nFails   = 0;
    logic [31:0] expLine [4];

    cache_mem_responder #(
        .LATENCY   (LAT),
        .MEM_WORDS (1024)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (reqValid),
        .o_req_ready   (reqReady),
        .i_req_write   (reqWrite),
        .i_req_addr    (reqAddr),
        .i_wdata_valid (wdataValid),
        .o_wdata_ready (wdataReady),
        .i_wdata       (wdata),
        .o_rsp_valid   (rspValid),
        .i_rsp_ready   (rspReady),
        .o_rsp_data    (rspData),
        .o_rsp_last    (rspLast),
        .o_fill_count  (fillCount),
        .o_wb_count    (wbCount)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Runaway guard in case a handshake never completes
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point shared by every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present a request and return just after the edge that accepts it
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input string tag);
        int guard = 0;
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        while (!reqReady && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_accept"}, 32'(reqReady), 32'd1);
        tick();
        reqValid = 1'b0;
    endtask

    // Collect a 4-beat fill against expLine, optionally stalling one beat
    task automatic collectFill(input int stallBeat, input int stallCycles, input string tag);
        int   lat    = 0;
        int   guard  = 0;
        int   beat   = 0;
        int   stalls = stallCycles;
        logic sawReq = 1'b0;
        rspReady = 1'b1;
        while (!rspValid && guard < 50) begin
            sawReq |= reqReady;
            tick();
            lat++;
            guard++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
        guard = 0;
        while (beat < 4 && guard < 50) begin
            sawReq |= reqReady;
            if (!rspValid) begin
                checkOutput({tag, "_valid_in_burst"}, 32'(rspValid), 32'd1);
            end else if (beat == stallBeat && stalls > 0) begin
                rspReady = 1'b0;
                checkOutput({tag, "_stall_data"}, rspData, expLine[beat]);
                checkOutput({tag, "_stall_last"}, 32'(rspLast), 32'(beat == 3));
                stalls--;
            end else begin
                rspReady = 1'b1;
                checkOutput($sformatf("%s_beat%0d_data", tag, beat), rspData, expLine[beat]);
                checkOutput($sformatf("%s_beat%0d_last", tag, beat), 32'(rspLast), 32'(beat == 3));
                beat++;
            end
            tick();
            guard++;
        end
        rspReady = 1'b0;
        checkOutput({tag, "_beats"}, 32'(beat), 32'd4);
        checkOutput({tag, "_rsp_drop"}, 32'(rspValid), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(reqReady), 32'd1);
        checkOutput({tag, "_busy_ready_low"}, 32'(sawReq), 32'd0);
    endtask

    task automatic readLine(input logic [11:0] addr, input int stallBeat, input int stallCycles, input string tag);
        applyStimulus(1'b0, addr, tag);
        collectFill(stallBeat, stallCycles, tag);
    endtask

    // Write expLine to a line and check the single zero-data ack
    task automatic writeLine(input logic [11:0] addr, input string tag);
        int   guard;
        int   lat     = 0;
        logic sawWrdy = 1'b0;
        applyStimulus(1'b1, addr, tag);
        for (int i = 0; i < 4; i++) begin
            wdataValid = 1'b1;
            wdata      = expLine[i];
            guard      = 0;
            while (!wdataReady && guard < 50) begin
                tick();
                guard++;
            end
            tick();
        end
        wdataValid = 1'b0;
        guard      = 0;
        while (!rspValid && guard < 50) begin
            sawWrdy |= wdataReady;
            tick();
            lat++;
            guard++;
        end
        checkOutput({tag, "_ack_latency"}, 32'(lat), 32'(LAT));
        checkOutput({tag, "_ack_data"}, rspData, 32'd0);
        checkOutput({tag, "_ack_last"}, 32'(rspLast), 32'd1);
        checkOutput({tag, "_wready_low"}, 32'(sawWrdy), 32'd0);
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        checkOutput({tag, "_ack_single"}, 32'(rspValid), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(reqReady), 32'd1);
    endtask

    // Directed sequence
    initial begin
        logic sawRsp;
        logic [15:0] expFill;
        logic [15:0] expWb;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
        checkOutput("rst_wdata_ready", 32'(wdataReady), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_rsp_last", 32'(rspLast), 32'd0);
        checkOutput("rst_rsp_data", rspData, 32'd0);
        checkOutput("rst_fill_count", 32'(fillCount), 32'd0);
        checkOutput("rst_wb_count", 32'(wbCount), 32'd0);
        rst = 1'b0;
        tick();

        // Plain fill, offset inside the line ignored: words 0x28..0x2B
        expLine = '{32'h28, 32'h29, 32'h2A, 32'h2B};
        readLine(12'h0A4, -1, 0, "fill0A4");

        // Writeback to the same line, then read it back
        expLine = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
        writeLine(12'h0A0, "wb0A0");
        readLine(12'h0A0, -1, 0, "rb0A0");

        // Cache stalls beat 1 for three cycles
        expLine = '{32'h30, 32'h31, 32'h32, 32'h33};
        readLine(12'h0C8, 1, 3, "stall");

        // req_valid held through a fill: the next request is taken right after
        expLine  = '{32'h40, 32'h41, 32'h42, 32'h43};
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 12'h100;
        tick();
        reqAddr  = 12'h200;
        collectFill(-1, 0, "hold1");
        tick();
        reqValid = 1'b0;
        checkOutput("hold2_accepted", 32'(reqReady), 32'd0);
        expLine = '{32'h80, 32'h81, 32'h82, 32'h83};
        collectFill(-1, 0, "hold2");

        // Reset after two writeback beats to line 0
        expLine = '{32'hBEEF0000, 32'hBEEF0001, 32'h2, 32'h3};
        applyStimulus(1'b1, 12'h000, "rstwb");
        wdataValid = 1'b1;
        wdata      = 32'hBEEF0000;
        tick();
        wdata      = 32'hBEEF0001;
        tick();
        wdataValid = 1'b0;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        checkOutput("rstwb_idle", 32'(reqReady), 32'd1);
        checkOutput("rstwb_wready", 32'(wdataReady), 32'd0);
        checkOutput("rstwb_fill_count", 32'(fillCount), 32'd0);
        checkOutput("rstwb_wb_count", 32'(wbCount), 32'd0);
        sawRsp = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            sawRsp |= rspValid;
            tick();
        end
        checkOutput("rstwb_no_ack", 32'(sawRsp), 32'd0);
        readLine(12'h000, -1, 0, "rstrd");

        // Two more writebacks and fills, including the top line
        expLine = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
        writeLine(12'h300, "wb300");
        readLine(12'h30C, -1, 0, "rb30C");
        expLine = '{32'h12345670, 32'h12345671, 32'h12345672, 32'h12345673};
        writeLine(12'hFF0, "wbFF0");
        readLine(12'hFF0, 2, 1, "rbFF0");

        // Three fills and two writebacks since the last reset
`ifdef CACHE_MEM_STATS_EN
        expFill = 16'd3;
        expWb   = 16'd2;
`else
        expFill = 16'd0;
        expWb   = 16'd0;
`endif
        checkOutput("fill_count", 32'(fillCount), 32'(expFill));
        checkOutput("wb_count", 32'(wbCount), 32'(expWb));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request accept to first response beat; legal range 1..15.
REQ-002 Parameter MEM_WORDS, default 1024: backing store depth in 32-bit words (4 KB, 12-bit byte address).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  cache presents a line request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_write  input  1  1 = line writeback, 0 = line fill.
REQ-008 req_addr  input  12  byte address; [11:7] tag, [6:4] set, [3:2] word, [1:0] byte; [3:0] ignored.
REQ-009 wdata_valid  input  1  writeback data beat valid.
REQ-010 wdata_ready  output  1  responder accepts a writeback beat.
REQ-011 wdata  input  32  writeback beat data.
REQ-012 rsp_valid  output  1  fill beat or writeback ack valid.
REQ-013 rsp_ready  input  1  cache accepts the response beat.
REQ-014 rsp_data  output  32  fill beat data; 0 on writeback ack.
REQ-015 rsp_last  output  1  final fill beat, or the single writeback ack.
REQ-016 fill_count  output  16  completed fills (see Configuration).
REQ-017 wb_count  output  16  completed writebacks (see Configuration).

Function
REQ-018 Line = 4 words; line base word index = req_addr[11:4]*4; beats always in order word 0,1,2,3 (no critical-word-first).
REQ-019 FSM states: IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_WAIT, WR_ACK.
REQ-020 req_ready = 1 only in IDLE; handshake = req_valid & req_ready; address and req_write captured on handshake.
REQ-021 IDLE -> RD_WAIT on read handshake, -> WR_DATA on write handshake; the latency counter loads LATENCY-1.
REQ-022 RD_WAIT decrements the counter each cycle; at 0 -> RD_BURST, so the first rsp_valid appears exactly LATENCY cycles after the handshake cycle.
REQ-023 RD_BURST: rsp_valid = 1, rsp_data = mem[base+beat]; beat advances only on rsp_valid & rsp_ready; rsp_data/rsp_last stay stable while stalled.
REQ-024 rsp_last = 1 on beat 3; its acceptance -> IDLE.
REQ-025 WR_DATA: wdata_ready = 1; each wdata_valid & wdata_ready writes mem[base+beat] = wdata; after the 4th beat -> WR_WAIT with the counter loaded to LATENCY-1.
REQ-026 WR_WAIT counts down as RD_WAIT does, then -> WR_ACK; WR_ACK drives rsp_valid = 1, rsp_last = 1, rsp_data = 0; acceptance -> IDLE.
REQ-027 wdata_ready = 0 outside WR_DATA; wdata_valid is ignored there.
REQ-028 rsp_valid = 0 outside RD_BURST and WR_ACK.
REQ-029 A read following a writeback to the same line returns the written data.
REQ-030 req_valid held during a burst is not accepted until IDLE; accept is earliest the cycle after the final response handshake.
REQ-031 Simulation initial content: mem[i] = i zero-extended to 32 bits.

Reset
REQ-032 rst forces IDLE, the beat counter and latency counter to 0, req_ready = 1, and wdata_ready = rsp_valid = rsp_last = 0, rsp_data = 0.
REQ-033 rst mid-burst abandons the transaction with no ack; words already written stay written; memory contents are never cleared by reset.
REQ-034 rst clears fill_count and wb_count to 0.

Configuration
REQ-035 Macro CACHE_MEM_STATS_EN defined: fill_count increments on each rsp_last handshake in RD_BURST; wb_count increments on each WR_ACK handshake; both saturate at 16'hFFFF.
REQ-036 Macro CACHE_MEM_STATS_EN undefined: no counter logic; fill_count and wb_count are tied to 0.

Verification
REQ-037 Reset, then read req_addr=12'h0A4 with rsp_ready=1: the first beat comes 4 cycles after accept; data 0x28,0x29,0x2A,0x2B; rsp_last on the 4th beat.
REQ-038 Write req_addr=12'h0A0 with beats 0xDEAD0000..0xDEAD0003, then read 12'h0A0: returns 0xDEAD0000..0xDEAD0003; one ack with rsp_data=0.
REQ-039 Read with rsp_ready low for 3 cycles on beat 1: beat 1 data held stable; 4 beats total, none lost or duplicated.
REQ-040 req_valid held high throughout a read: req_ready=0 until the burst ends; the second request is accepted the cycle after rsp_last is accepted.
REQ-041 Assert rst after 2 writeback beats to line 0: FSM in IDLE next cycle with no ack; words 0-1 updated, words 2-3 still hold 2 and 3.
REQ-042 With CACHE_MEM_STATS_EN, 3 fills and 2 writebacks: fill_count=3, wb_count=2; without it, both read 0.
